// File: rtl/mod_n_counter_ctrl.sv
// mod_n_counter_ctrl: programmable modulo-N counter sequencer.
// It has an IDLE/RUN/DONE command FSM with one-shot and continuous modes.
// It exposes the count, its bitwise inverse, and a terminal-count strobe.
module mod_n_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             mode,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_lat_q, mod_lat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             at_term;

    assign at_term = (count_q == mod_lat_q);

    // Next-state and next-count decode. Priority is stop > start > hold/count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        count_d   = count_q;
        mod_lat_d = mod_lat_q;
        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (!stop && start) begin
                    state_d   = S_RUN;
                    mod_lat_d = mod_val;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (hold) begin
                    count_d = count_q;
                end else if (at_term) begin
                    if (mode) begin
                        count_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                count_d = mod_lat_q;
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d   = S_RUN;
                    count_d   = '0;
                    mod_lat_d = mod_val;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, count, latched modulus and decoded status flops with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            mod_lat_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mod_lat_q <= mod_lat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign count     = count_q;
    assign count_bar = ~count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    // tc is the only combinational output: it is high during the cycle that precedes a wrap or finish.
    assign tc        = (state_q == S_RUN) && !hold && !stop && at_term;

endmodule

// File: doc/mod_n_counter_ctrl.md
Name: mod_n_counter_ctrl

Overview:
Sequencing controller for the 4-bit counter datapath. It owns a synchronous 4-bit count register and runs it as a programmable modulo-N counter under a start/stop/hold command interface. It supports one-shot and continuous modes and flags the terminal count. It sits between a control FSM or testbench and the display or downstream logic that consumes Q/Qbar-style count outputs.

Parameters:
WIDTH, 4, count register width. All ports below marked WIDTH use this value; test plan uses 4.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  level-sampled start command; acted on only in IDLE or DONE
stop  input  1  abort command; returns to IDLE
hold  input  1  freeze count while in RUN
mode  input  1  0 = one-shot, 1 = continuous
mod_val  input  WIDTH  terminal value; count sequence is 0..mod_val
count  output  WIDTH  current count (registered)
count_bar  output  WIDTH  bitwise inverse of count, always
tc  output  1  terminal-count strobe (combinational)
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset, when rst=1 at an edge:
  - state=IDLE, count=0, count_bar=all ones, mod_lat=0, busy=0, done=0.
  - rst overrides every other input, including mid-run.
- States: IDLE, RUN, DONE. The encoding is free, but there must be no other reachable states.
- Command priority at each edge: rst > stop > start > count/hold.
- IDLE:
  - count held at 0.
  - start=1 (and stop=0): go to RUN, count=0, mod_lat<=mod_val.
  - Otherwise stay in IDLE.
- RUN:
  - stop=1: go to IDLE, count=0.
  - hold=1: count unchanged, state unchanged.
  - count!=mod_lat and hold=0: count<=count+1.
  - count==mod_lat, hold=0, mode=1: count<=0, stay in RUN (wrap).
  - count==mod_lat, hold=0, mode=0: go to DONE, count stays at mod_lat.
  - start is ignored.
- DONE:
  - count held at mod_lat, done=1.
  - stop=1: go to IDLE, count=0.
  - start=1: go to RUN, count=0, re-latch mod_val.
- tc = (state==RUN) & ~hold & ~stop & (count==mod_lat). It is high for exactly the cycle preceding the wrap or finish edge.
- mod_val is sampled only on entry to RUN. Changes during RUN/DONE have no effect.
- mod_val=0:
  - One-shot: one RUN cycle with tc=1, then DONE with count=0.
  - Continuous: count stays 0, tc=1 every non-held RUN cycle.
- Mode is sampled every cycle. Toggling it mid-run affects the next terminal event only.
- Latency:
  - start to busy = 1 cycle.
  - In one-shot, start to done = mod_val+2 cycles with no holds.
  - Each hold cycle adds one.
- Counter arithmetic is modulo 2^WIDTH. The wrap is defined only by mod_lat compare, and natural overflow cannot occur.
- Outputs busy/done are decoded from registered state (glitch-free). tc is the only combinational output.

Test Plan:
- Reset, then idle 3 cycles -> count=0, count_bar=4'hF, busy=0, done=0, tc=0.
- mode=0, mod_val=5, 1-cycle start pulse:
  - count goes 0,1,2,3,4,5; tc=1 only while count=5.
  - Next edge: done=1, busy=0, count held at 5.
  - Another start restarts from 0.
- mode=1, mod_val=3, start, run 12 cycles:
  - count 0,1,2,3,0,1,2,3,0,1,2,3.
  - tc high 3 times, at count=3; busy stays 1.
- mode=1, mod_val=7, hold asserted for 4 cycles at count=2:
  - count stays 2 and tc stays 0 during hold.
  - Resumes with 3 after hold drops.
  - mod_val changed to 1 mid-run: ignored, wrap still after 7.
- In RUN at count=4, start=1 and stop=1 on the same edge -> IDLE, count=0, busy=0. With mod_val=0 and mode=0 -> one RUN cycle with tc=1, then done=1, count=0.
- rst pulsed while in RUN at count=6 and in DONE -> next edge IDLE, count=0, done=0; start must be re-issued to resume.
